// File: rtl/rv32_alu_regfile_slice_if.sv
// rv32_alu_regfile_slice_if: bundles every non-clock/reset signal of the RV32I datapath
// slice.
//   master : core FSM side. Drives addresses, write data, ALU operands/control and
//            the result-register load enable.
//   slave  : datapath slice side. Returns read data, ALU result/flags and result_q.
interface rv32_alu_regfile_slice_if;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr0;
  logic [4:0]  rd_addr1;
  logic [31:0] rd_data0;
  logic [31:0] rd_data1;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        overflow;
  logic        zero;
  logic        equal;
  logic        res_ena;
  logic [31:0] result_q;

  modport master (
    output wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
    output src_a, src_b, alu_control, res_ena,
    input  rd_data0, rd_data1, alu_result, overflow, zero, equal, result_q
  );

  modport slave (
    input  wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
    input  src_a, src_b, alu_control, res_ena,
    output rd_data0, rd_data1, alu_result, overflow, zero, equal, result_q
  );
endinterface

// File: rtl/rv32_alu_regfile_slice.sv
// rv32_alu_regfile_slice: RV32I datapath slice for the multicycle core.
//   - 32x32 register file: two combinational read ports and one synchronous write port.
//     x0 is hardwired to zero.
//   - Combinational 32-bit ALU with overflow, zero and equal flags.
//   - Enable-gated result register that holds the ALU result for writeback.
// Ports:
//   clk : clock. All state updates on the rising edge.
//   rst : synchronous, active-high reset. It clears the register file and loads
//         result_q with RESULT_RESET.
//   bus : rv32_alu_regfile_slice_if.slave. It carries the register-file, ALU and
//         result-register signals.
// Optional feature: define REGFILE_WRITE_BYPASS_EN to forward wr_data to a read port
// whose address matches the active write address in the same cycle.
module rv32_alu_regfile_slice #(
  parameter logic [31:0] RESULT_RESET = 32'h0000_0000
) (
  input logic                     clk,
  input logic                     rst,
  rv32_alu_regfile_slice_if.slave bus
);

  logic [31:0] r_regs [32];
  logic [31:0] r_result;

  logic [31:0] w_rd_data0;
  logic [31:0] w_rd_data1;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu_result;
  logic        w_overflow;

  // Register file and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
      r_result <= RESULT_RESET;
    end else begin
      if (bus.wr_ena && (bus.wr_addr != 5'd0)) begin
        r_regs[bus.wr_addr] <= bus.wr_data;
      end
      if (bus.res_ena) begin
        r_result <= w_alu_result;
      end
    end
  end

  // Read ports. The x0 override is applied last so that forwarding can never leak into x0.
  always_comb begin
    w_rd_data0 = r_regs[bus.rd_addr0];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (bus.wr_ena && (bus.wr_addr == bus.rd_addr0)) begin
      w_rd_data0 = bus.wr_data;
    end
`endif
    if (bus.rd_addr0 == 5'd0) begin
      w_rd_data0 = '0;
    end
  end

  always_comb begin
    w_rd_data1 = r_regs[bus.rd_addr1];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (bus.wr_ena && (bus.wr_addr == bus.rd_addr1)) begin
      w_rd_data1 = bus.wr_data;
    end
`endif
    if (bus.rd_addr1 == 5'd0) begin
      w_rd_data1 = '0;
    end
  end

  // ALU
  assign w_sum   = bus.src_a + bus.src_b;
  assign w_diff  = bus.src_a - bus.src_b;
  assign w_shamt = bus.src_b[4:0];

  always_comb begin
    w_alu_result = '0;
    w_overflow   = 1'b0;
    case (bus.alu_control)
      4'b0001: w_alu_result = bus.src_a & bus.src_b;
      4'b0010: w_alu_result = bus.src_a | bus.src_b;
      4'b0011: w_alu_result = bus.src_a ^ bus.src_b;
      4'b0101: w_alu_result = bus.src_a << w_shamt;
      4'b0110: w_alu_result = bus.src_a >> w_shamt;
      4'b0111: w_alu_result = $signed(bus.src_a) >>> w_shamt;
      4'b1000: begin
        w_alu_result = w_sum;
        // Same-sign operands with a result whose sign flipped
        w_overflow   = (bus.src_a[31] == bus.src_b[31]) && (w_sum[31] != bus.src_a[31]);
      end
      4'b1100: begin
        w_alu_result = w_diff;
        // Opposite-sign operands with a result whose sign differs from a
        w_overflow   = (bus.src_a[31] != bus.src_b[31]) && (w_diff[31] != bus.src_a[31]);
      end
      4'b1101: w_alu_result = {31'b0, $signed(bus.src_a) < $signed(bus.src_b)};
      4'b1111: w_alu_result = {31'b0, bus.src_a < bus.src_b};
      default: w_alu_result = '0;
    endcase
  end

  assign bus.rd_data0   = w_rd_data0;
  assign bus.rd_data1   = w_rd_data1;
  assign bus.alu_result = w_alu_result;
  assign bus.overflow   = w_overflow;
  assign bus.zero       = (w_alu_result == 32'd0);
  assign bus.equal      = (bus.src_a == bus.src_b);
  assign bus.result_q   = r_result;

endmodule

// File: tb/tb_rv32_alu_regfile_slice.sv
// Self-checking bench for rv32_alu_regfile_slice: directed cases plus randomized cycles
// checked against an arithmetic reference model of the register file and ALU.
module tb_rv32_alu_regfile_slice;
  localparam logic [31:0] ResetVal = 32'hA5A5_0F0F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rv32_alu_regfile_slice_if bus ();

  rv32_alu_regfile_slice #(
    .RESULT_RESET(ResetVal)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference state
  logic [31:0] m_regs [32];
  logic [31:0] m_result;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {overflow, result}; overflow judged from the exact signed sum.
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    logic signed [31:0] as = a;
    int sh = int'(b % 32);
    logic [31:0] r = 32'd0;
    logic ovf = 1'b0;
    case (op)
      4'd1:  r = a & b;
      4'd2:  r = a | b;
      4'd3:  r = a ^ b;
      4'd5:  r = a << sh;
      4'd6:  r = a >> sh;
      4'd7:  r = as >>> sh;
      4'd8:  begin s = sa + sb; r = a + b; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd12: begin s = sa - sb; r = a - b; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd13: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd15: r = ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {ovf, r};
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (bus.wr_ena && bus.wr_addr == addr) return bus.wr_data;
`endif
    return m_regs[addr];
  endfunction

  // Drive at the falling edge, then check all combinational outputs.
  task automatic set(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] ra0, input logic [4:0] ra1, input logic [31:0] a,
                     input logic [31:0] b, input logic [3:0] op, input logic re);
    logic [32:0] e;
    @(negedge clk);
    bus.wr_ena = we;  bus.wr_addr = wa;  bus.wr_data = wd;
    bus.rd_addr0 = ra0; bus.rd_addr1 = ra1;
    bus.src_a = a; bus.src_b = b; bus.alu_control = op; bus.res_ena = re;
    #1;
    e = ref_alu(op, a, b);
    check("rd_data0", bus.rd_data0, ref_read(ra0));
    check("rd_data1", bus.rd_data1, ref_read(ra1));
    check("alu_result", bus.alu_result, e[31:0]);
    check("overflow", {31'd0, bus.overflow}, {31'd0, e[32]});
    check("zero", {31'd0, bus.zero}, {31'd0, e[31:0] == 32'd0});
    check("equal", {31'd0, bus.equal}, {31'd0, a == b});
  endtask

  // Rising edge: advance the model, then check result_q.
  task automatic clk_edge();
    logic [32:0] e;
    @(posedge clk);
    e = ref_alu(bus.alu_control, bus.src_a, bus.src_b);
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_result = ResetVal;
    end else begin
      if (bus.wr_ena && bus.wr_addr != 5'd0) m_regs[bus.wr_addr] = bus.wr_data;
      if (bus.res_ena) m_result = e[31:0];
    end
    #1;
    check("result_q", bus.result_q, m_result);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    foreach (m_regs[i]) m_regs[i] = 32'hx;
    m_result = 32'hx;
    bus.wr_ena = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_addr0 = '0; bus.rd_addr1 = '0;
    bus.src_a = '0; bus.src_b = '0; bus.alu_control = '0; bus.res_ena = 1'b0;

    // Reset: all registers read zero, result_q loads its reset value
    rst = 1'b1;
    clk_edge();
    clk_edge();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      set(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 32'd0, 32'd0, 4'd0, 1'b0);
      check("reset_rd", bus.rd_data0, 32'd0);
    end
    check("reset_result_q", bus.result_q, ResetVal);

    // Write x5, read it on both ports
    set(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    clk_edge();
    set(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 32'd0, 32'd0, 4'd0, 1'b0);
    check("x5_port0", bus.rd_data0, 32'hDEAD_BEEF);
    check("x5_port1", bus.rd_data1, 32'hDEAD_BEEF);

    // Writes to x0 are discarded
    set(1'b1, 5'd0, 32'h0000_1234, 5'd0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    clk_edge();
    set(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    check("x0_zero", bus.rd_data0, 32'd0);

    // ALU directed cases
    set(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 32'h7FFF_FFFF, 32'd1, 4'b1000, 1'b0);
    check("add_ovf_res", bus.alu_result, 32'h8000_0000);
    check("add_ovf_flag", {31'd0, bus.overflow}, 32'd1);
    set(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 32'd5, 32'd5, 4'b1100, 1'b0);
    check("sub_res", bus.alu_result, 32'd0);
    check("sub_zero", {31'd0, bus.zero}, 32'd1);
    check("sub_equal", {31'd0, bus.equal}, 32'd1);
    check("sub_ovf", {31'd0, bus.overflow}, 32'd0);
    set(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 4'b1101, 1'b0);
    check("slt", bus.alu_result, 32'd1);
    set(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 4'b1111, 1'b0);
    check("sltu", bus.alu_result, 32'd0);
    set(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'h8000_0000, 32'h24, 4'b0111, 1'b0);
    check("sra", bus.alu_result, 32'hF800_0000);
    set(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'h8000_0000, 32'h24, 4'b0110, 1'b0);
    check("srl", bus.alu_result, 32'h0800_0000);
    set(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd1, 32'd31, 4'b0101, 1'b0);
    check("sll", bus.alu_result, 32'h8000_0000);
    set(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'h1234_5678, 32'h0F0F_0F0F, 4'b0000, 1'b0);
    check("invalid_res", bus.alu_result, 32'd0);
    check("invalid_zero", {31'd0, bus.zero}, 32'd1);

    // Result register load, then hold while the ALU result changes
    set(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd1, 32'd2, 4'b1000, 1'b1);
    clk_edge();
    check("res_load", bus.result_q, 32'd3);
    set(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd10, 32'd20, 4'b1000, 1'b0);
    clk_edge();
    check("res_hold", bus.result_q, 32'd3);

    // Reset has priority over an active write and result load
    set(1'b1, 5'd9, 32'h0000_0055, 5'd0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    clk_edge();
    rst = 1'b1;
    set(1'b1, 5'd9, 32'h0000_AAAA, 5'd9, 5'd9, 32'd4, 32'd4, 4'b1000, 1'b1);
    clk_edge();
    rst = 1'b0;
    set(1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    check("rst_mid_write", bus.rd_data0, 32'd0);
    check("rst_result_q", bus.result_q, ResetVal);

    // Same-cycle write/read of x7
    set(1'b1, 5'd7, 32'h0000_1111, 5'd0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    clk_edge();
    set(1'b1, 5'd7, 32'h0000_2222, 5'd7, 5'd7, 32'd0, 32'd0, 4'd0, 1'b0);
`ifdef REGFILE_WRITE_BYPASS_EN
    check("rdw_x7", bus.rd_data0, 32'h0000_2222);
`else
    check("rdw_x7", bus.rd_data0, 32'h0000_1111);
`endif
    clk_edge();
    set(1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    check("x7_after", bus.rd_data0, 32'h0000_2222);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      a = rand_operand();
      b = ($urandom_range(0, 7) == 0) ? a : rand_operand();
      set(1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom), a, b,
          4'($urandom), 1'($urandom));
      clk_edge();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
